// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
// Holds the controller state encoding and the half-subtractor primitive
// that the full-subtractor bit cell is built from.
package serial_sub_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Half subtractor x - y: returns {borrow, diff}.
   // Two of these chained give br' = (~a & b) | (~(a ^ b) & br).
   function automatic logic [1:0] half_sub(input logic x, input logic y);
      return {(~x & y), (x ^ y)};
   endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_bit.sv
// fs_bit: combinational one-bit full subtractor (ai - bi - bin).
// Built from two half-subtractor stages; the borrow-out is the OR of
// the two stage borrows.
module fs_bit
   import serial_sub_ctrl_pkg::*;
(
   input  logic ai,
   input  logic bi,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic [1:0] hs0;
   logic [1:0] hs1;

   // First stage subtracts the operand bits, second stage the incoming borrow.
   always_comb begin
      hs0  = half_sub(ai, bi);
      hs1  = half_sub(hs0[0], bin);
      d    = hs1[0];
      bout = hs0[1] | hs1[1];
   end

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor controller.
// Latches a/b on an accepted start, then feeds one shared fs_bit cell from
// the operand shift-register LSBs, one bit per clock, LSB first, chaining
// the borrow through a flop. diff fills from the MSB side so that after
// WIDTH steps bit 0 lands in diff[0]. done pulses for the single DONE cycle.
// Optional feature: define SERSUB_OVF_EN to register a signed-overflow flag
// on ovf; otherwise ovf is tied low and no overflow logic exists.
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bw,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bw_q, bw_d;
   logic             d_bit;
   logic             b_bit;
`ifdef SERSUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   fs_bit u_fs_bit (
      .ai   (a_sh_q[0]),
      .bi   (b_sh_q[0]),
      .bin  (br_q),
      .d    (d_bit),
      .bout (b_bit)
   );

   // Next-state, datapath shifting and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      diff_d  = diff_q;
      br_d    = br_q;
      bw_d    = bw_q;
`ifdef SERSUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_sh_d  = a;
               b_sh_d  = b;
               cnt_d   = '0;
               br_d    = 1'b0;
               diff_d  = '0;
               bw_d    = 1'b0;
`ifdef SERSUB_OVF_EN
               ovf_d   = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Shift-then-patch keeps WIDTH=1 legal (no zero-width slices).
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            diff_d = diff_q >> 1;
            diff_d[WIDTH-1] = d_bit;
            br_d   = b_bit;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               bw_d    = b_bit;
`ifdef SERSUB_OVF_EN
               // On the last step the shift LSBs hold the operand MSBs.
               ovf_d   = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ d_bit);
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter, shift registers and result flops with async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         diff_q  <= diff_d;
         br_q    <= br_d;
         bw_q    <= bw_d;
      end
   end

`ifdef SERSUB_OVF_EN
   // Overflow flag, held alongside diff until the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign diff = diff_q;
   assign bw   = bw_q;

endmodule
